// File: rtl/reg_file.sv
// reg_file: 32 x 32 MIPS general-purpose register file.
// Two combinational read ports (rs, rt), one synchronous write port,
// $0 hardwired to zero, optional same-cycle write-through bypass and a
// saturating committed-write counter for debug visibility.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [15:0]       wr_count
);

  localparam int NREGS = 1 << ADDR_W;

  // Entry 0 has no storage; it is synthesised as constant zero on the read side.
  logic [DATA_W-1:0] regs_q [1:NREGS-1];
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic              wr_commit_s;
  logic              rs_bypass_s;
  logic              rt_bypass_s;

  // A write only counts when enabled and aimed at a real register.
  always_comb begin
    wr_commit_s = 1'b0;
    if (we && (wr_addr != {ADDR_W{1'b0}})) begin
      wr_commit_s = 1'b1;
    end else begin
      wr_commit_s = 1'b0;
    end
  end

  // Bypass match per port; the whole path is removed when BYPASS is 0.
  always_comb begin
    rs_bypass_s = 1'b0;
    rt_bypass_s = 1'b0;
    if ((BYPASS != 0) && wr_commit_s) begin
      rs_bypass_s = (rs_addr == wr_addr);
      rt_bypass_s = (rt_addr == wr_addr);
    end else begin
      rs_bypass_s = 1'b0;
      rt_bypass_s = 1'b0;
    end
  end

  // Read port 1: zero for $0, bypassed write data on match, else stored value.
  always_comb begin
    rs_data = {DATA_W{1'b0}};
    if (rs_addr == {ADDR_W{1'b0}}) begin
      rs_data = {DATA_W{1'b0}};
    end else if (rs_bypass_s) begin
      rs_data = wr_data;
    end else begin
      rs_data = regs_q[rs_addr];
    end
  end

  // Read port 2: same selection as port 1, evaluated independently.
  always_comb begin
    rt_data = {DATA_W{1'b0}};
    if (rt_addr == {ADDR_W{1'b0}}) begin
      rt_data = {DATA_W{1'b0}};
    end else if (rt_bypass_s) begin
      rt_data = wr_data;
    end else begin
      rt_data = regs_q[rt_addr];
    end
  end

  // Counter next state: +1 per committed write, sticks at all-ones.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_commit_s && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Register array update; synchronous reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_commit_s) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Write counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count_q <= 16'h0000;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file. Two instances share stimulus:
// dut_bp has the write-through bypass enabled, dut_nb has it disabled.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rs_data_bp;
  logic [31:0] rt_data_bp;
  logic [15:0] wr_count_bp;
  logic [31:0] rs_data_nb;
  logic [31:0] rt_data_nb;
  logic [15:0] wr_count_nb;

  int n_checks;
  int n_errors;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_bp (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rs_data  (rs_data_bp),
    .rt_data  (rt_data_bp),
    .wr_count (wr_count_bp)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rs_data  (rs_data_nb),
    .rt_data  (rt_data_nb),
    .wr_count (wr_count_nb)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One committed-write cycle; inputs change 1 unit after the edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    we      = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n   = 1'b0;
    we      = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'h0;
    rs_addr = 5'd0;
    rt_addr = 5'd0;

    // Reset for two edges, then sweep all addresses.
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      #1;
      check_eq("rst_rs_bp", rs_data_bp, 32'h0);
      check_eq("rst_rt_bp", rt_data_bp, 32'h0);
      check_eq("rst_rs_nb", rs_data_nb, 32'h0);
      check_eq("rst_rt_nb", rt_data_nb, 32'h0);
    end
    check_eq("rst_cnt_bp", {16'h0, wr_count_bp}, 32'h0);
    check_eq("rst_cnt_nb", {16'h0, wr_count_nb}, 32'h0);

    // Basic writes feeding an ALU add.
    do_write(5'd1, 32'h0000_2222);
    do_write(5'd2, 32'h0000_1111);
    rs_addr = 5'd1;
    rt_addr = 5'd2;
    #1;
    check_eq("wr1_rs_bp", rs_data_bp, 32'h0000_2222);
    check_eq("wr2_rt_bp", rt_data_bp, 32'h0000_1111);
    check_eq("wr1_rs_nb", rs_data_nb, 32'h0000_2222);
    check_eq("wr2_rt_nb", rt_data_nb, 32'h0000_1111);
    check_eq("alu_sum", rs_data_bp + rt_data_bp, 32'h0000_3333);
    check_eq("cnt2", {16'h0, wr_count_bp}, 32'd2);

    // Write to $0 is discarded, even in the cycle it is presented.
    we      = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hFFFF_FFFF;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    #1;
    check_eq("r0_same_bp", rs_data_bp, 32'h0);
    check_eq("r0_same_rt_bp", rt_data_bp, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    check_eq("r0_after_bp", rs_data_bp, 32'h0);
    check_eq("r0_after_nb", rs_data_nb, 32'h0);
    check_eq("r0_cnt", {16'h0, wr_count_bp}, 32'd2);

    // Same-cycle bypass vs old value.
    we      = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'h0000_5555;
    rs_addr = 5'd5;
    rt_addr = 5'd5;
    #1;
    check_eq("byp_rs_bp", rs_data_bp, 32'h0000_5555);
    check_eq("byp_rt_bp", rt_data_bp, 32'h0000_5555);
    check_eq("byp_rs_nb", rs_data_nb, 32'h0);
    check_eq("byp_rt_nb", rt_data_nb, 32'h0);
    rt_addr = 5'd1;
    #1;
    check_eq("byp_rt_other", rt_data_bp, 32'h0000_2222);
    @(posedge clk);
    #1;
    we = 1'b0;
    rt_addr = 5'd5;
    #1;
    check_eq("post_rs_bp", rs_data_bp, 32'h0000_5555);
    check_eq("post_rs_nb", rs_data_nb, 32'h0000_5555);
    check_eq("post_rt_nb", rt_data_nb, 32'h0000_5555);
    check_eq("cnt3", {16'h0, wr_count_nb}, 32'd3);

    // Reset has priority over a simultaneous write.
    rst_n   = 1'b0;
    we      = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    we      = 1'b0;
    rs_addr = 5'd3;
    rt_addr = 5'd1;
    #1;
    check_eq("rstw_r3_bp", rs_data_bp, 32'h0);
    check_eq("rstw_r3_nb", rs_data_nb, 32'h0);
    check_eq("rstw_r1_bp", rt_data_bp, 32'h0);
    check_eq("rstw_cnt", {16'h0, wr_count_bp}, 32'd0);
    rst_n = 1'b1;
    do_write(5'd3, 32'h0000_ABCD);
    check_eq("rel_r3_bp", rs_data_bp, 32'h0000_ABCD);
    check_eq("rel_r3_nb", rs_data_nb, 32'h0000_ABCD);
    check_eq("rel_cnt", {16'h0, wr_count_bp}, 32'd1);

    // Back-to-back writes to one address: last wins.
    we      = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h0000_0001;
    @(posedge clk);
    #1;
    wr_data = 32'h0000_0002;
    @(posedge clk);
    #1;
    we      = 1'b0;
    rs_addr = 5'd7;
    #1;
    check_eq("b2b_r7", rs_data_nb, 32'h0000_0002);
    check_eq("b2b_cnt", {16'h0, wr_count_nb}, 32'd3);

    // A reset pulse between edges is never sampled.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("glitch_r7", rs_data_nb, 32'h0000_0002);
    check_eq("glitch_cnt", {16'h0, wr_count_nb}, 32'd3);

    // Drive counter to 0xFFFE, then past saturation.
    we      = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h0000_0009;
    repeat (65531) @(posedge clk);
    #1;
    check_eq("cnt_fffe", {16'h0, wr_count_bp}, 32'h0000_FFFE);
    wr_data = 32'h0000_000A;
    @(posedge clk);
    #1;
    check_eq("cnt_ffff", {16'h0, wr_count_bp}, 32'h0000_FFFF);
    wr_data = 32'h0000_000B;
    @(posedge clk);
    #1;
    wr_data = 32'h0000_000C;
    @(posedge clk);
    #1;
    we      = 1'b0;
    rs_addr = 5'd9;
    #1;
    check_eq("sat_bp", {16'h0, wr_count_bp}, 32'h0000_FFFF);
    check_eq("sat_nb", {16'h0, wr_count_nb}, 32'h0000_FFFF);
    check_eq("sat_r9", rs_data_bp, 32'h0000_000C);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
